// File: rtl/tcd1209d_line_capture.sv
// tcd1209d_line_capture: frames TCD1209D lines from the ADC, measures the dark level and streams the effective pixels
// Ports: sys_clk/sys_rst clock and async reset; enable, dark_sub_en, ovf_clr controls;
//        pclk, os_tvalid, adc_data from the driver/ADC; m_tdata/m_tvalid/m_tready/m_tuser/m_tlast output stream;
//        dark_level, line_cnt, overflow, frame_err status.
module tcd1209d_line_capture #(
  parameter int DW = 12,
  parameter int LINE_WIDTH = 2088,
  parameter int DARK_START = 13,
  parameter int DARK_SHIFT = 4,
  parameter int ACT_START = 32,
  parameter int ACT_PIX = 2048,
  parameter int SAMPLE_DLY = 10
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          enable,
  input  logic          dark_sub_en,
  input  logic          ovf_clr,
  input  logic          pclk,
  input  logic          os_tvalid,
  input  logic [DW-1:0] adc_data,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tuser,
  output logic          m_tlast,
  output logic [DW-1:0] dark_level,
  output logic [15:0]   line_cnt,
  output logic          overflow,
  output logic          frame_err
);
  localparam int AW = DW + DARK_SHIFT;
  localparam logic [11:0] LAST_IDX = 12'(LINE_WIDTH - 1);
  localparam logic [11:0] D_LO = 12'(DARK_START);
  localparam logic [11:0] D_HI = 12'(DARK_START + (1 << DARK_SHIFT) - 1);
  localparam logic [11:0] D_LATCH = 12'(ACT_START - 1);
  localparam logic [11:0] A_LO = 12'(ACT_START);
  localparam logic [11:0] A_HI = 12'(ACT_START + ACT_PIX - 1);
  localparam logic [3:0] SDLY = 4'(SAMPLE_DLY);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
  state_t state, state_nx;
  logic pclk_d, after_line, rise, smp, take, done, short_line, long_line, act, stall;
  logic [3:0] dly;
  logic [11:0] idx, pix;
  logic [AW-1:0] acc;
  logic [DW-1:0] cur_dark, word;
  always_comb begin
    rise = pclk & ~pclk_d;
    smp = dly == SDLY;
    pix = (state == CAPTURE) ? idx : '0;
    // after_line blocks a line that never dropped os_tvalid from being taken as a new one
    take = smp && os_tvalid && (state == CAPTURE || (state == ARMED && !after_line));
    done = take && state == CAPTURE && idx == LAST_IDX;
    short_line = smp && state == CAPTURE && !os_tvalid;
    long_line = smp && state == ARMED && after_line && os_tvalid;
    act = take && pix >= A_LO && pix <= A_HI;
    stall = m_tvalid && !m_tready;
    word = !dark_sub_en ? adc_data : (adc_data < cur_dark) ? '0 : adc_data - cur_dark;
  end
  always_comb begin
    state_nx = state;
    if (smp)
      case (state)
        IDLE:    state_nx = (enable && !os_tvalid) ? ARMED : IDLE;
        ARMED:   state_nx = !os_tvalid ? ARMED : after_line ? IDLE : CAPTURE;
        default: state_nx = !os_tvalid ? ARMED : (idx == LAST_IDX) ? (enable ? ARMED : IDLE) : CAPTURE;
      endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      pclk_d <= 1'b0;
      dly <= '0;
      after_line <= 1'b0;
      idx <= '0;
      acc <= '0;
      cur_dark <= '0;
      dark_level <= '0;
      line_cnt <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tuser <= 1'b0;
      m_tlast <= 1'b0;
    end else begin
      state <= state_nx;
      pclk_d <= pclk;
      dly <= rise ? 4'd1 : (dly == '0 || dly == SDLY) ? '0 : dly + 4'd1;
      frame_err <= short_line | long_line;
      after_line <= done ? 1'b1 : (smp && !os_tvalid) ? 1'b0 : after_line;
      if (take) begin
        idx <= (state == CAPTURE) ? idx + 12'd1 : 12'd1;
        acc <= (pix == '0) ? '0 : (pix >= D_LO && pix <= D_HI) ? acc + AW'(adc_data) : acc;
      end
      if (take && pix == D_LATCH)
        cur_dark <= DW'(acc >> DARK_SHIFT);
      if (done) begin
        line_cnt <= line_cnt + 16'd1;
        dark_level <= cur_dark;
      end
      overflow <= (act && stall) | (overflow & ~ovf_clr);
      if (act && !stall) begin
        m_tvalid <= 1'b1;
        m_tdata <= word;
        m_tuser <= pix == A_LO;
        m_tlast <= pix == A_HI;
      end else if (m_tready)
        m_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tcd1209d_line_capture.sv
// tb_tcd1209d_line_capture: directed scoreboard bench for tcd1209d_line_capture on a shortened line geometry
module tb_tcd1209d_line_capture;
  localparam int DW = 12, LW = 88, DS = 13, DSH = 4, AS = 32, AP = 48, SD = 10, GAP = 4, NONE = -100;
  logic sys_clk = 0, sys_rst = 1, enable = 0, dark_sub_en = 0, ovf_clr = 0, pclk = 0, os_tvalid = 0, m_tready = 1;
  logic [DW-1:0] adc_data = '0;
  logic [DW-1:0] m_tdata, dark_level;
  logic m_tvalid, m_tuser, m_tlast, overflow, frame_err;
  logic [15:0] line_cnt;
  int checks = 0, errors = 0, wc = 0, fe_cnt = 0, exp_lc = 0, exp_dark = 0;
  logic [DW+1:0] sbq[$];
  tcd1209d_line_capture #(.DW(DW), .LINE_WIDTH(LW), .DARK_START(DS), .DARK_SHIFT(DSH),
    .ACT_START(AS), .ACT_PIX(AP), .SAMPLE_DLY(SD)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .dark_sub_en(dark_sub_en), .ovf_clr(ovf_clr),
    .pclk(pclk), .os_tvalid(os_tvalid), .adc_data(adc_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tuser(m_tuser), .m_tlast(m_tlast), .dark_level(dark_level),
    .line_cnt(line_cnt), .overflow(overflow), .frame_err(frame_err));
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge sys_clk) begin
    #1;
    if (m_tvalid && m_tready) begin
      wc++;
      chk("q_nonempty", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) chk("word", 32'({m_tdata, m_tuser, m_tlast}), 32'(sbq.pop_front()));
    end
    if (frame_err) fe_cnt++;
  end
  function automatic int pat(input int mode, input int p);
    if (mode == 0) return p % 4096;
    if (p >= DS && p < DS + 16) return 100;
    if (p >= AS) return (p % 2 == 0) ? 90 : 500;
    return 0;
  endfunction
  task automatic run_line(input int nvalid, input bit cap, input int mode, input int stall_pix,
                          input int en_off_pix, input int rst_pix);
    int sum = 0, dark = 0, v = 0;
    bit live = cap;
    wc = 0;
    fe_cnt = 0;
    for (int p = -GAP; p < nvalid + GAP; p++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge sys_clk);
        pclk = c < 8;
        if (c == 0) begin
          os_tvalid = p >= 0 && p < nvalid;
          v = os_tvalid ? pat(mode, p) : 0;
          adc_data = DW'(v);
          if (p == en_off_pix) enable = 0;
          if (os_tvalid) begin
            if (p >= DS && p < DS + 16) sum += v;
            if (p == AS - 1) dark = sum >> DSH;
            if (live && p >= AS && p < AS + AP && !(p > stall_pix && p <= stall_pix + 2))
              sbq.push_back({DW'(dark_sub_en ? (v > dark ? v - dark : 0) : v), p == AS, p == AS + AP - 1});
          end
        end
        if (p == stall_pix && c == 11) m_tready = 0;
        if (p == stall_pix + 3 && c == 3) m_tready = 1;
        if (p == rst_pix && c == 4) begin
          #3 sys_rst = 1;
          #1;
          chk("rst_ctl", 32'({m_tvalid, m_tuser, m_tlast, overflow, frame_err, m_tdata}), 32'd0);
          chk("rst_cnt", 32'({dark_level, line_cnt}), 32'd0);
          sbq.delete();
          live = 0;
          exp_lc = 0;
          exp_dark = 0;
        end
        if (p == rst_pix && c == 8) sys_rst = 0;
      end
    end
    if (live && nvalid == LW) begin
      exp_lc++;
      exp_dark = dark;
    end
  endtask
  task automatic end_line(input string tag, input int words, input int fe);
    chk({tag, "_words"}, 32'(wc), 32'(words));
    chk({tag, "_line_cnt"}, 32'(line_cnt), 32'(exp_lc));
    chk({tag, "_dark"}, 32'(dark_level), 32'(exp_dark));
    chk({tag, "_q_empty"}, 32'(sbq.size()), 32'd0);
    chk({tag, "_frame_err"}, 32'(fe_cnt), 32'(fe));
  endtask
  initial begin
    repeat (3) @(negedge sys_clk);
    chk("reset_ctl", 32'({m_tvalid, m_tuser, m_tlast, overflow, frame_err, m_tdata}), 32'd0);
    chk("reset_cnt", 32'({dark_level, line_cnt}), 32'd0);
    sys_rst = 0;
    enable = 1;
    run_line(LW, 1, 0, NONE, NONE, NONE);
    end_line("raw1", AP, 0);
    run_line(LW, 1, 0, NONE, NONE, NONE);
    end_line("raw2", AP, 0);
    dark_sub_en = 1;
    run_line(LW, 1, 1, NONE, NONE, NONE);
    end_line("dsub", AP, 0);
    dark_sub_en = 0;
    run_line(LW, 1, 1, NONE, NONE, NONE);
    end_line("nodsub", AP, 0);
    chk("ovf_pre", 32'(overflow), 32'd0);
    run_line(LW, 1, 0, 50, NONE, NONE);
    end_line("stall", AP - 2, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    @(negedge sys_clk) ovf_clr = 1;
    @(negedge sys_clk) ovf_clr = 0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    run_line(40, 1, 0, NONE, NONE, NONE);
    end_line("short", 8, 1);
    run_line(LW, 1, 0, NONE, NONE, NONE);
    end_line("after_short", AP, 0);
    run_line(LW, 1, 0, NONE, 40, NONE);
    end_line("en_off", AP, 0);
    run_line(LW, 0, 0, NONE, NONE, NONE);
    end_line("disabled", 0, 0);
    enable = 1;
    run_line(LW, 1, 0, NONE, NONE, NONE);
    end_line("reenabled", AP, 0);
    run_line(LW, 1, 0, NONE, NONE, 60);
    end_line("rst_line", 28, 0);
    run_line(LW, 1, 0, NONE, NONE, NONE);
    end_line("after_rst", AP, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tcd1209d_line_capture.md
Name: tcd1209d_line_capture

Overview:
- Receive side of the TCD1209D driver timing interface: consumes `pclk` and `os_tvalid` from the CCD driver, plus the external ADC's parallel output word.
- Samples one ADC word per pixel period and frames each 2088-pixel line.
- Measures the dark level from the light-shielded pixels and optionally subtracts it.
- Emits only the effective pixels as a ready/valid stream with start-of-line and end-of-line markers, toward line buffer/DMA logic.

Parameters:
- DW, 12, ADC data width.
- LINE_WIDTH, 2088, total pixels per line while `os_tvalid`=1.
- DARK_START, 13, pixel index of the first shielded pixel.
- DARK_SHIFT, 4, log2 of the shielded pixel count (16 pixels, indices 13..28).
- ACT_START, 32, index of the first effective pixel.
- ACT_PIX, 2048, number of effective pixels.
- SAMPLE_DLY, 10, `sys_clk` cycles after the `pclk` rising edge at which data is sampled; legal range 1..14.

Ports:
- sys_clk  in  1  system clock, 100 MHz; same clock the driver runs on.
- sys_rst  in  1  reset, asynchronous, active-high.
- enable  in  1  capture enable.
- dark_sub_en  in  1  1 = subtract the dark level from output pixels.
- ovf_clr  in  1  clears `overflow`.
- pclk  in  1  pixel clock from the driver; 16 `sys_clk` period, high for 8 cycles.
- os_tvalid  in  1  driver line-valid.
- adc_data  in  DW  ADC output word.
- m_tdata  out  DW  pixel data.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tuser  out  1  first effective pixel of the line.
- m_tlast  out  1  last effective pixel of the line.
- dark_level  out  DW  dark level of the last completed line.
- line_cnt  out  16  count of completed lines, wraps at 65535 to 0.
- overflow  out  1  sticky: a pixel was dropped.
- frame_err  out  1  one-cycle pulse on a malformed line.

Behaviour:
- **Reset values:** all outputs 0; state IDLE; all counters and the accumulator 0.
- **Edge detect:** register `pclk` in `pclk_d`. The rising edge is `pclk` & ~`pclk_d`.
- **Sample strobe:** a delay counter fires `smp` exactly SAMPLE_DLY cycles after the edge-detect cycle. In that cycle, `adc_data` and `os_tvalid` are captured together.
- **State machine** (all transitions occur on `smp` only):
  - IDLE -> ARMED when `enable`=1 and sampled `os_tvalid`=0.
  - ARMED -> CAPTURE when sampled `os_tvalid`=1. This sample is pixel index 0.
  - CAPTURE: the pixel index increments on each `smp`.
  - After index LINE_WIDTH-1 the line is complete: `line_cnt`+1 and the dark level is committed. Then go to ARMED if `enable`=1, else IDLE.
  - A sampled `os_tvalid`=0 in CAPTURE before index LINE_WIDTH-1 is a short line: pulse `frame_err`, go to ARMED. `line_cnt` is unchanged.
  - A sampled `os_tvalid`=1 in ARMED immediately after a completed line (no intervening 0) is a long line: pulse `frame_err`, go to IDLE-wait-low. Pixel data is discarded.
  - Deasserting `enable` mid-line does not abort the line.
- **Dark level:**
  - Accumulator width DW+DARK_SHIFT. Cleared at index 0.
  - Adds samples at indices DARK_START..DARK_START+2^DARK_SHIFT-1.
  - At index ACT_START-1, latch `cur_dark` = accumulator >> DARK_SHIFT.
  - `dark_level` output updates to `cur_dark` at line completion only.
- **Output data:**
  - Indices ACT_START..ACT_START+ACT_PIX-1 produce one output word each.
  - With `dark_sub_en`=1: the word is sample - `cur_dark`, clamped at 0 when the sample < `cur_dark`.
  - With `dark_sub_en`=0: the raw sample.
  - `m_tuser`=1 at index ACT_START. `m_tlast`=1 at index ACT_START+ACT_PIX-1.
  - Pixels outside the effective range are never output.
- **Latency:** `m_tvalid` rises the cycle after `smp`.
- **Handshake:**
  - Single holding register. The word is held stable until `m_tvalid` & `m_tready`.
  - If a new pixel arrives while the holding register is still full, the new pixel is dropped and `overflow` is set. A set in the same cycle as `ovf_clr` wins over the clear.
  - A word accepted and a new word loaded in the same cycle is legal and is not an overflow.
- **Reset mid-line:** everything returns to IDLE. A partial line is never output and `m_tlast` is not generated.

Test Plan:
1. Driver model with f_cnt=2200, `enable`=1, `adc_data`=pixel index mod 4096, `m_tready`=1 -> 2048 words per line with values 32..2079, `m_tuser` on 32, `m_tlast` on 2079, `line_cnt` increments per line.
2. Shielded pixels 13..28 = 100 and active pixels = 90/500, `dark_sub_en`=1 -> `dark_level`=100; outputs 0 for 90 and 400 for 500. With `dark_sub_en`=0 -> raw 90/500.
3. `m_tready` held low for 40 `sys_clk` during the active region -> exactly 2 pixels dropped, `overflow`=1 until `ovf_clr`, no spurious words output.
4. `os_tvalid` dropped after 1000 pixels -> `frame_err` pulses once, `line_cnt` unchanged, next full line is captured normally.
5. `enable` deasserted at pixel 500 -> the current line completes (2048 words); no further lines are captured until `enable` returns; capture then restarts at the next `os_tvalid` rise.
6. `sys_rst` asserted asynchronously at pixel 1500 -> all outputs 0 immediately, no `m_tlast` for that line, and the following line is captured completely.
